bus_default_responder: RTL

- Wishbone-classic responder on the target side of the system bus.
- Terminates any strobe that no slave claims within a decode window:
  - addresses inside an exempt window (config-record area) get ack_o with fixed read data;
  - all other unclaimed addresses get err_o.
- Records the first faulting cycle in sticky capture registers and counts all faults.
- Complements the initiator-side timeout monitor: this block is the slave-side terminator, so the monitor fires only for hung slaves.

---
 rtl/bus_resp_pkg.sv | 28 ++
 rtl/bus_fault_capture.sv | 62 ++++++
 rtl/bus_default_responder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/bus_resp_pkg.sv
// ============================================================================
// bus_resp_pkg : shared types and helpers for the bus default responder
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package bus_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } resp_state_e;

  localparam int unsigned c_fault_cnt_w = 8;

  function automatic logic exempt_match(
    input logic [31:0] adr,
    input logic [31:0] base,
    input logic [31:0] mask
  );
    return (adr & mask) == (base & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_fault_capture.sv
// ============================================================================
// bus_fault_capture : sticky first-fault latch plus saturating fault counter
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module bus_fault_capture
  import bus_resp_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     event_i,
  input  logic [31:0]              adr_i,
  input  logic                     we_i,
  input  logic                     clr_i,
  output logic                     fault_o,
  output logic [31:0]              fault_adr_o,
  output logic                     fault_we_o,
  output logic [c_fault_cnt_w-1:0] fault_cnt_o
);

  localparam logic [c_fault_cnt_w-1:0] c_cnt_max = '1;

  logic                     r_fault;
  logic [31:0]              r_adr;
  logic                     r_we;
  logic [c_fault_cnt_w-1:0] r_cnt;

  // A fault arriving together with clr_i starts a fresh record.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fault <= 1'b0;
      r_adr   <= 32'd0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
    end else if (event_i) begin
      if (clr_i) begin
        r_cnt <= c_fault_cnt_w'(1);
      end else if (r_cnt != c_cnt_max) begin
        r_cnt <= r_cnt + c_fault_cnt_w'(1);
      end
      if (clr_i || !r_fault) begin
        r_fault <= 1'b1;
        r_adr   <= adr_i;
        r_we    <= we_i;
      end
    end else if (clr_i) begin
      r_fault <= 1'b0;
      r_adr   <= 32'd0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
    end
  end

  assign fault_o     = r_fault;
  assign fault_adr_o = r_adr;
  assign fault_we_o  = r_we;
  assign fault_cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: rtl/bus_default_responder.sv
// ============================================================================
// bus_default_responder : terminates unclaimed Wishbone strobes (ack or err)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module bus_default_responder
  import bus_resp_pkg::*;
#(
  parameter logic [7:0]  pDecodeDelay = 8'd4,
  parameter logic [31:0] pExemptAdr   = 32'hFFDCFFE0,
  parameter logic [31:0] pExemptMask  = 32'hFFFFFFF0,
  parameter logic [31:0] pExemptData  = 32'h00000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic        claimed_i,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] dat_o,
  input  logic        clr_i,
  output logic        fault_o,
  output logic [31:0] fault_adr_o,
  output logic        fault_we_o,
  output logic [7:0]  fault_cnt_o
);

  resp_state_e r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_ack, w_ack_nxt;
  logic        r_err, w_err_nxt;
  logic [31:0] r_dat, w_dat_nxt;
  logic        w_capture;
  logic        w_req;
  logic        w_exempt;

  assign w_req    = cyc_i & stb_i & ~claimed_i;
  assign w_exempt = exempt_match(adr_i, pExemptAdr, pExemptMask);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_dat   <= w_dat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_dat_nxt   = 32'd0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = 8'd1;
        end
      end
      WAIT: begin
        // Losing the request here means a slave or the master took over.
        if (!w_req) begin
          w_state_nxt = IDLE;
        end else if (r_cnt < pDecodeDelay) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end else begin
          w_state_nxt = RESP;
          if (w_exempt) begin
            w_ack_nxt = 1'b1;
            w_dat_nxt = pExemptData;
          end else begin
            w_err_nxt = 1'b1;
            w_capture = 1'b1;
          end
        end
      end
      RESP: begin
        w_state_nxt = cyc_i ? HOLD : IDLE;
      end
      HOLD: begin
        if (!cyc_i || !stb_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  bus_fault_capture u_capture (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .event_i     (w_capture),
    .adr_i       (adr_i),
    .we_i        (we_i),
    .clr_i       (clr_i),
    .fault_o     (fault_o),
    .fault_adr_o (fault_adr_o),
    .fault_we_o  (fault_we_o),
    .fault_cnt_o (fault_cnt_o)
  );

  assign ack_o = r_ack;
  assign err_o = r_err;
  assign dat_o = r_dat;

  a_delay_legal : assert property (@(posedge clk_i) pDecodeDelay != 8'd0);

endmodule

`default_nettype wire
